// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller.
//   sel_t      : operand-mux select codes driven onto m2/m3
//   REG_AW_DEF : default register address width (16 architectural registers)
package hazard_fwd_ctrl_pkg;

    localparam int REG_AW_DEF = 4;

    // 2'b10 is reserved and never driven.
    typedef enum logic [1:0] {
        SEL_REG = 2'b00,  // register-file operand from buffer2
        SEL_ALU = 2'b01,  // ALU result from buffer3
        SEL_WB  = 2'b11   // m5 writeback value
    } sel_t;

endpackage

// File: rtl/hazard_fwd_ctrl_slot_reg.sv
// One scoreboard slot: {valid, dst, wen, load} of one in-flight instruction.
//   clk, reset     : clock, synchronous active-high reset (clears the slot)
//   hold           : freeze the slot contents
//   bubble         : load an empty slot instead of the next_* fields
//   next_*         : fields captured on a non-held, non-bubble edge
//   valid/dst/wen/load : current slot contents
module hazard_fwd_ctrl_slot_reg #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              bubble,
    input  logic              next_valid,
    input  logic [REG_AW-1:0] next_dst,
    input  logic              next_wen,
    input  logic              next_load,
    output logic              valid,
    output logic [REG_AW-1:0] dst,
    output logic              wen,
    output logic              load
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            dst   <= '0;
            wen   <= 1'b0;
            load  <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                valid <= 1'b0;
                dst   <= '0;
                wen   <= 1'b0;
                load  <= 1'b0;
            end else begin
                valid <= next_valid;
                dst   <= next_dst;
                wen   <= next_wen;
                load  <= next_load;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding / hazard controller for the 16-bit pipeline.
// Keeps an EX/MEM/WB scoreboard of in-flight destination registers and
// produces registered select codes for operand muxes m2 (operand 1) and
// m3 (operand 2) for the instruction in EX. Detects load-use hazards and
// raises a combinational one-cycle stall while a bubble enters EX.
// Ports:
//   in_clk, in_reset           : clock, synchronous active-high reset
//   in_id_valid                : decode holds a valid instruction
//   in_id_src1/src2, use1/use2 : decode source registers and read enables
//   in_id_dst, in_id_wen       : decode destination register and write enable
//   in_id_load                 : decode instruction is a load
//   in_flush                   : taken branch, kill decode and EX
//   in_hold                    : global freeze, all state holds
//   out_cntrl_m2/m3            : select codes for the instruction in EX
//   out_stall                  : hold PC/decode this cycle (combinational)
//   out_stall_cnt              : saturating count of non-held stall cycles
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter bit R0_ZERO = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_id_valid,
    input  logic [REG_AW-1:0] in_id_src1,
    input  logic [REG_AW-1:0] in_id_src2,
    input  logic              in_id_use1,
    input  logic              in_id_use2,
    input  logic [REG_AW-1:0] in_id_dst,
    input  logic              in_id_wen,
    input  logic              in_id_load,
    input  logic              in_flush,
    input  logic              in_hold,
    output logic [1:0]        out_cntrl_m2,
    output logic [1:0]        out_cntrl_m3,
    output logic              out_stall,
    output logic [CNT_W-1:0]  out_stall_cnt
);

    logic              ex_valid,  mem_valid,  wb_valid;
    logic [REG_AW-1:0] ex_dst,    mem_dst,    wb_dst;
    logic              ex_wen,    mem_wen,    wb_wen;
    logic              ex_load,   mem_load,   wb_load;

    logic ex_bubble;
    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic stall, capture;
    sel_t m2_next, m3_next, m2_q, m3_q;
    logic [CNT_W-1:0] cnt_q;

    // A slot produces src when it holds a valid writer of that register.
    // Register 0 is never a producer when it is hardwired to zero.
    function automatic logic slot_match(
        input logic              valid,
        input logic              wen,
        input logic [REG_AW-1:0] dst,
        input logic [REG_AW-1:0] src
    );
        return valid && wen && (dst == src) && !(R0_ZERO && (src == '0));
    endfunction

    // Decode fields enter EX only when decode is valid, not stalled and not flushed.
    assign ex_bubble = !capture;

    hazard_fwd_ctrl_slot_reg #(.REG_AW(REG_AW)) u_ex_slot (
        .clk        (in_clk),
        .reset      (in_reset),
        .hold       (in_hold),
        .bubble     (ex_bubble),
        .next_valid (in_id_valid),
        .next_dst   (in_id_dst),
        .next_wen   (in_id_wen),
        .next_load  (in_id_load),
        .valid      (ex_valid),
        .dst        (ex_dst),
        .wen        (ex_wen),
        .load       (ex_load)
    );

    hazard_fwd_ctrl_slot_reg #(.REG_AW(REG_AW)) u_mem_slot (
        .clk        (in_clk),
        .reset      (in_reset),
        .hold       (in_hold),
        .bubble     (1'b0),
        .next_valid (ex_valid),
        .next_dst   (ex_dst),
        .next_wen   (ex_wen),
        .next_load  (ex_load),
        .valid      (mem_valid),
        .dst        (mem_dst),
        .wen        (mem_wen),
        .load       (mem_load)
    );

    hazard_fwd_ctrl_slot_reg #(.REG_AW(REG_AW)) u_wb_slot (
        .clk        (in_clk),
        .reset      (in_reset),
        .hold       (in_hold),
        .bubble     (1'b0),
        .next_valid (mem_valid),
        .next_dst   (mem_dst),
        .next_wen   (mem_wen),
        .next_load  (mem_load),
        .valid      (wb_valid),
        .dst        (wb_dst),
        .wen        (wb_wen),
        .load       (wb_load)
    );

    // The WB slot completes the scoreboard but a producer there is already
    // visible through the register file, so nothing forwards from it.
    logic unused_slot_bits;
    assign unused_slot_bits = ^{wb_valid, wb_dst, wb_wen, wb_load, mem_load};

    always_comb begin
        ex_hit1  = in_id_use1 && slot_match(ex_valid,  ex_wen,  ex_dst,  in_id_src1);
        ex_hit2  = in_id_use2 && slot_match(ex_valid,  ex_wen,  ex_dst,  in_id_src2);
        mem_hit1 = in_id_use1 && slot_match(mem_valid, mem_wen, mem_dst, in_id_src1);
        mem_hit2 = in_id_use2 && slot_match(mem_valid, mem_wen, mem_dst, in_id_src2);

        // A load in EX cannot feed the next instruction; flush overrides the stall.
        stall   = in_id_valid && ex_load && (ex_hit1 || ex_hit2) && !in_flush;
        capture = in_id_valid && !stall && !in_flush;

        // Nearest producer wins: EX (ALU result) before MEM (writeback value).
        m2_next = SEL_REG;
        m3_next = SEL_REG;
        if (capture) begin
            if (ex_hit1)       m2_next = SEL_ALU;
            else if (mem_hit1) m2_next = SEL_WB;
            if (ex_hit2)       m3_next = SEL_ALU;
            else if (mem_hit2) m3_next = SEL_WB;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            m2_q  <= SEL_REG;
            m3_q  <= SEL_REG;
            cnt_q <= '0;
        end else if (!in_hold) begin
            m2_q <= m2_next;
            m3_q <= m3_next;
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_cntrl_m2  = m2_q;
    assign out_cntrl_m3  = m3_q;
    assign out_stall     = stall;
    assign out_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed scenarios followed by randomized
// traffic, all checked against an instruction-level pipeline model.
module tb_hazard_fwd_ctrl;

    localparam int AW  = 4;
    localparam bit R0Z = 1'b1;
    localparam int CW  = 4;   // narrow counter so saturation is reachable
    localparam int CNT_MAX = (1 << CW) - 1;

    // clock / reset
    logic in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    logic          in_reset = 1'b1;
    logic          in_id_valid = 1'b0;
    logic [AW-1:0] in_id_src1 = '0, in_id_src2 = '0, in_id_dst = '0;
    logic          in_id_use1 = 1'b0, in_id_use2 = 1'b0;
    logic          in_id_wen = 1'b0, in_id_load = 1'b0;
    logic          in_flush = 1'b0, in_hold = 1'b0;
    logic [1:0]    out_cntrl_m2, out_cntrl_m3;
    logic          out_stall;
    logic [CW-1:0] out_stall_cnt;

    hazard_fwd_ctrl #(.REG_AW(AW), .R0_ZERO(R0Z), .CNT_W(CW)) dut (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_id_valid   (in_id_valid),
        .in_id_src1    (in_id_src1),
        .in_id_src2    (in_id_src2),
        .in_id_use1    (in_id_use1),
        .in_id_use2    (in_id_use2),
        .in_id_dst     (in_id_dst),
        .in_id_wen     (in_id_wen),
        .in_id_load    (in_id_load),
        .in_flush      (in_flush),
        .in_hold       (in_hold),
        .out_cntrl_m2  (out_cntrl_m2),
        .out_cntrl_m3  (out_cntrl_m3),
        .out_stall     (out_stall),
        .out_stall_cnt (out_stall_cnt)
    );

    // reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit          v;
        bit [AW-1:0] dst;
        bit          wen;
        bit          ld;
    } instr_t;

    instr_t      pipe [3];
    logic [1:0]  exp_m2, exp_m3;
    int          exp_cnt;
    bit          last_stall;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit produces(int slot, logic [AW-1:0] src);
        return pipe[slot].v && pipe[slot].wen && pipe[slot].dst == src;
    endfunction

    function automatic bit reads(bit use_it, logic [AW-1:0] src);
        return use_it && !(R0Z && src == 0);
    endfunction

    // operand value source: the youngest older instruction writing it
    function automatic logic [1:0] model_sel(bit use_it, logic [AW-1:0] src);
        if (!reads(use_it, src)) return 2'b00;
        if (produces(0, src))    return 2'b01;
        if (produces(1, src))    return 2'b11;
        return 2'b00;
    endfunction

    // decode must wait when the instruction just ahead is a load it reads from
    function automatic bit model_stall();
        bit dep;
        dep = (reads(in_id_use1, in_id_src1) && produces(0, in_id_src1)) ||
              (reads(in_id_use2, in_id_src2) && produces(0, in_id_src2));
        return in_id_valid && !in_flush && pipe[0].ld && dep;
    endfunction

    task automatic model_step();
        bit st, take;
        if (in_reset) begin
            foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
            exp_m2 = 2'b00; exp_m3 = 2'b00; exp_cnt = 0;
        end else if (!in_hold) begin
            st   = model_stall();
            take = in_id_valid && !st && !in_flush;
            exp_m2 = take ? model_sel(in_id_use1, in_id_src1) : 2'b00;
            exp_m3 = take ? model_sel(in_id_use2, in_id_src2) : 2'b00;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = take ? '{1, in_id_dst, in_id_wen, in_id_load} : '{0, 0, 0, 0};
            if (st && exp_cnt < CNT_MAX) exp_cnt++;
        end
        exp_q.push_back({exp_m2, exp_m3});
    endtask

    // driver tasks
    task automatic set_instr(input bit v, input logic [AW-1:0] d, input bit w, input bit ld,
                             input logic [AW-1:0] s1, input bit u1,
                             input logic [AW-1:0] s2, input bit u2);
        in_id_valid = v; in_id_dst = d; in_id_wen = w; in_id_load = ld;
        in_id_src1 = s1; in_id_use1 = u1; in_id_src2 = s2; in_id_use2 = u2;
    endtask

    task automatic set_nop();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_alu(input logic [AW-1:0] d, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        set_instr(1, d, 1, 0, s1, 1, s2, 1);
    endtask

    task automatic set_load(input logic [AW-1:0] d, input logic [AW-1:0] base);
        set_instr(1, d, 1, 1, base, 1, 0, 0);
    endtask

    // one cycle: entered at a negedge with inputs already driven
    task automatic tick(input string tag, output bit stall_seen);
        logic [3:0] e;
        bit exp_stall;
        #1;
        exp_stall  = model_stall();
        stall_seen = out_stall;
        check({tag, " stall"}, out_stall, exp_stall);
        model_step();
        @(posedge in_clk); #1;
        e = exp_q.pop_front();
        check({tag, " m2"},  out_cntrl_m2,  e[3:2]);
        check({tag, " m3"},  out_cntrl_m3,  e[1:0]);
        check({tag, " cnt"}, out_stall_cnt, exp_cnt);
        last_stall = exp_stall;
        @(negedge in_clk);
    endtask

    task automatic drain(input int n);
        bit s;
        set_nop();
        for (int i = 0; i < n; i++) tick("drain", s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit s;
        foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
        exp_m2 = 2'b00; exp_m3 = 2'b00; exp_cnt = 0; last_stall = 0;

        // reset held for two cycles
        in_reset = 1'b1;
        repeat (2) @(posedge in_clk);
        #1;
        check("reset m2",    out_cntrl_m2,  2'b00);
        check("reset m3",    out_cntrl_m3,  2'b00);
        check("reset stall", out_stall,     1'b0);
        check("reset cnt",   out_stall_cnt, 0);
        @(negedge in_clk);
        in_reset = 1'b0;

        // ADD r3 ; ADD r4,r3,r5
        set_alu(3, 1, 2);  tick("t1 add3", s);
        set_alu(4, 3, 5);  tick("t1 add4", s);
        check("t1 m2 alu", out_cntrl_m2, 2'b01);
        check("t1 m3 reg", out_cntrl_m3, 2'b00);
        drain(3);

        // ADD r3 ; NOP ; SUB r6,r1,r3
        set_alu(3, 1, 2);  tick("t2 add3", s);
        set_nop();         tick("t2 nop", s);
        set_alu(6, 1, 3);  tick("t2 sub", s);
        check("t2 m2 reg", out_cntrl_m2, 2'b00);
        check("t2 m3 wb",  out_cntrl_m3, 2'b11);
        drain(3);

        // LOAD r2 ; ADD r7,r2,r2 -> one stall, then both operands from writeback
        set_load(2, 1);    tick("t3 load", s);
        set_alu(7, 2, 2);  tick("t3 use", s);
        check("t3 stall on", s, 1'b1);
        check("t3 cnt", out_stall_cnt, 1);
        tick("t3 retry", s);
        check("t3 stall off", s, 1'b0);
        check("t3 m2 wb", out_cntrl_m2, 2'b11);
        check("t3 m3 wb", out_cntrl_m3, 2'b11);
        drain(3);

        // load-use with flush in the same cycle
        set_load(2, 1);    tick("t4 load", s);
        set_alu(7, 2, 2);  in_flush = 1'b1; tick("t4 flush", s);
        in_flush = 1'b0;
        check("t4 stall", s, 1'b0);
        check("t4 m2", out_cntrl_m2, 2'b00);
        check("t4 m3", out_cntrl_m3, 2'b00);
        check("t4 cnt", out_stall_cnt, 1);
        set_alu(9, 7, 7);  tick("t4 after", s);   // r7 writer was killed
        check("t4 after m2", out_cntrl_m2, 2'b00);
        drain(3);

        // r0 writer followed by r0 reader
        set_alu(0, 1, 2);  tick("t5 w0", s);
        set_alu(5, 0, 0);  tick("t5 r0", s);
        check("t5 m2", out_cntrl_m2, 2'b00);
        check("t5 m3", out_cntrl_m3, 2'b00);
        drain(3);

        // same with a 3-cycle hold in the middle
        set_alu(0, 1, 2);  tick("t6 w0", s);
        set_alu(5, 0, 0);  in_hold = 1'b1;
        for (int i = 0; i < 3; i++) tick("t6 hold", s);
        in_hold = 1'b0;    tick("t6 r0", s);
        check("t6 m2", out_cntrl_m2, 2'b00);
        check("t6 m3", out_cntrl_m3, 2'b00);
        drain(3);

        // hold freezes registered selects of a forwarded pair
        set_alu(3, 1, 2);  tick("t7 add3", s);
        set_alu(4, 3, 5);  tick("t7 add4", s);
        set_alu(6, 1, 4);  in_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("t7 hold", s);
            check("t7 frozen m2", out_cntrl_m2, 2'b01);
            check("t7 frozen m3", out_cntrl_m3, 2'b00);
        end
        in_hold = 1'b0;    tick("t7 sub", s);
        check("t7 m2", out_cntrl_m2, 2'b00);
        check("t7 m3", out_cntrl_m3, 2'b01);
        drain(3);

        // drive the stall counter into saturation
        for (int i = 0; i < 16; i++) begin
            set_load(2, 1);   tick("sat load", s);
            set_alu(7, 2, 2); tick("sat use", s);
            tick("sat retry", s);
        end
        check("sat cnt", out_stall_cnt, CNT_MAX);
        drain(3);

        // randomized traffic; a stalled instruction is usually retried
        for (int i = 0; i < 400; i++) begin
            if (!last_stall || $urandom_range(0, 9) == 0) begin
                set_instr($urandom_range(0, 6) != 0,
                          AW'($urandom_range(0, 5)), $urandom_range(0, 4) != 0,
                          $urandom_range(0, 2) == 0,
                          AW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            end
            in_flush = $urandom_range(0, 11) == 0;
            in_hold  = $urandom_range(0, 9) == 0;
            in_reset = $urandom_range(0, 99) == 0;
            tick("rnd", s);
        end
        in_flush = 1'b0; in_hold = 1'b0; in_reset = 1'b0;
        drain(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
